pulse_train_gen: RTL and testbench

//   Programmable pulse-train generator: successor to the single-cycle periodic pulser.

---
 rtl/pulse_train_gen.sv | 86 ++++++++
 tb/tb_pulse_train_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: continuous or N-pulse burst output, start/stop control,
// period/width reloaded only at period boundaries so updates never truncate a pulse.
module pulse_train_gen #(
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         start,
    input  logic         stop,
    input  logic         mode,
    input  logic [N-1:0] period,
    input  logic [N-1:0] width,
    input  logic [M-1:0] burst,
    output logic         out,
    output logic         busy,
    output logic         done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t       state;
    logic [N-1:0] cnt;
    logic [N-1:0] per_q;
    logic [N-1:0] wid_q;
    logic [M-1:0] left_q;
    logic         mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            per_q  <= '0;
            wid_q  <= '0;
            left_q <= '0;
            mode_q <= 1'b0;
            done   <= 1'b0;
        end else if (!ena) begin
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mode && (burst == '0)) begin
                            done <= 1'b1;
                        end else begin
                            state  <= RUN;
                            cnt    <= '0;
                            per_q  <= period;
                            wid_q  <= width;
                            mode_q <= mode;
                            left_q <= burst;
                        end
                    end
                end
                RUN: begin
                    // stop takes priority over a wrap in the same cycle
                    if (stop) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == per_q) begin
                        cnt   <= '0;
                        per_q <= period;
                        wid_q <= width;
                        if (mode_q) begin
                            left_q <= left_q - 1'b1;
                            if (left_q == {{(M-1){1'b0}}, 1'b1}) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign out  = (state == RUN) && (cnt < wid_q);

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: vector table, directed corner sequences,
// and randomized traffic checked against a cycle-level behavioural model.
module tb_pulse_train_gen;

    logic       clk = 1'b0;
    logic       rst, ena, start, stop, mode;
    logic [7:0] period, width, burst;
    logic       out, busy, done;

    int total = 0;
    int bad   = 0;

    // behavioural model state (plain integers)
    bit m_running = 0;
    bit m_bmode   = 0;
    bit m_done    = 0;
    int m_ph      = 0;
    int m_per     = 0;
    int m_wid     = 0;
    int m_left    = 0;

    typedef struct {
        bit      rst, ena, start, stop, mode;
        int      period, width, burst;
        bit      e_out, e_busy, e_done;
    } vec_t;

    pulse_train_gen #(.N(8), .M(8)) dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop), .mode(mode),
        .period(period), .width(width), .burst(burst),
        .out(out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // advance the model by one clock using the inputs present at the edge
    task automatic model_step();
        if (rst) begin
            m_running = 0; m_ph = 0; m_per = 0; m_wid = 0; m_left = 0; m_done = 0;
        end else if (ena) begin
            m_done = 0;
            if (!m_running) begin
                if (start) begin
                    if (mode && burst == 0) m_done = 1;
                    else begin
                        m_running = 1; m_ph = 0; m_per = period; m_wid = width;
                        m_bmode = mode; m_left = burst;
                    end
                end
            end else if (stop) begin
                m_running = 0; m_ph = 0;
            end else if (m_ph == m_per) begin
                m_ph = 0; m_per = period; m_wid = width;
                if (m_bmode) begin
                    m_left--;
                    if (m_left == 0) begin m_running = 0; m_done = 1; end
                end
            end else begin
                m_ph++;
            end
        end else begin
            m_done = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("out_vs_model",  int'(out),  int'(m_running && (m_ph < m_wid)));
        check("busy_vs_model", int'(busy), int'(m_running));
        check("done_vs_model", int'(done), int'(m_done));
    endtask

    task automatic idle_inputs();
        rst = 0; ena = 1; start = 0; stop = 0;
    endtask

    task automatic launch(input bit md, input int p, input int w, input int b);
        idle_inputs();
        start = 1; mode = md; period = 8'(p); width = 8'(w); burst = 8'(b);
        tick();
        start = 0;
    endtask

    vec_t vecs[$];
    bit   held;
    bit   exp3[9] = '{0, 0, 0, 1, 1, 0, 1, 1, 0};

    initial begin
        rst = 1; ena = 1; start = 0; stop = 0; mode = 0;
        period = 0; width = 0; burst = 0;

        // rst ena st sp md per wid bur   out busy done
        vecs.push_back('{1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 4, 2, 0,  0, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 0, 4, 2, 0,  0, 0, 0}); // stop in IDLE ignored
        vecs.push_back('{0, 1, 1, 0, 0, 4, 2, 0,  1, 1, 0}); // continuous start
        vecs.push_back('{0, 1, 0, 0, 0, 4, 2, 0,  1, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 4, 2, 0,  0, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 4, 2, 0,  0, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 4, 2, 0,  0, 1, 0});
        vecs.push_back('{0, 1, 1, 0, 0, 4, 2, 0,  1, 1, 0}); // start in RUN ignored
        vecs.push_back('{0, 1, 0, 0, 0, 4, 2, 0,  1, 1, 0});
        vecs.push_back('{0, 1, 0, 1, 0, 4, 2, 0,  0, 0, 0}); // stop
        vecs.push_back('{0, 1, 1, 0, 1, 2, 1, 3,  1, 1, 0}); // burst of 3, k+1
        vecs.push_back('{0, 1, 0, 0, 1, 2, 1, 3,  0, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 2, 1, 3,  0, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 2, 1, 3,  1, 1, 0}); // k+4
        vecs.push_back('{0, 1, 0, 0, 1, 2, 1, 3,  0, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 2, 1, 3,  0, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 2, 1, 3,  1, 1, 0}); // k+7
        vecs.push_back('{0, 1, 0, 0, 1, 2, 1, 3,  0, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 2, 1, 3,  0, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 2, 1, 3,  0, 0, 1}); // k+10 done
        vecs.push_back('{0, 1, 0, 0, 1, 2, 1, 3,  0, 0, 0});
        vecs.push_back('{0, 1, 1, 1, 1, 3, 2, 0,  0, 0, 1}); // burst==0, start beats stop
        vecs.push_back('{0, 1, 0, 0, 1, 3, 2, 0,  0, 0, 0});
        vecs.push_back('{0, 1, 1, 1, 0, 0, 1, 0,  1, 1, 0}); // start&stop: start wins, period 0
        vecs.push_back('{0, 1, 0, 0, 0, 0, 1, 0,  1, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 0, 1, 0,  1, 1, 0});
        vecs.push_back('{0, 1, 0, 1, 0, 0, 1, 0,  0, 0, 0});

        foreach (vecs[i]) begin
            rst = vecs[i].rst; ena = vecs[i].ena; start = vecs[i].start;
            stop = vecs[i].stop; mode = vecs[i].mode;
            period = 8'(vecs[i].period); width = 8'(vecs[i].width); burst = 8'(vecs[i].burst);
            tick();
            check($sformatf("vec%0d_out", i),  int'(out),  int'(vecs[i].e_out));
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
            check($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].e_done));
        end

        // period change 4->2 at cnt=1 takes effect only after the current period
        launch(0, 4, 2, 0);
        tick();
        period = 8'd2;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("reperiod_%0d", i), int'(out), int'(exp3[i]));
        end
        stop = 1; tick(); stop = 0;

        // ena low mid-pulse freezes the train
        launch(0, 4, 3, 0);
        tick();
        held = out;
        ena = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("freeze_out", int'(out), int'(held));
            check("freeze_busy", int'(busy), 1);
        end
        ena = 1;
        for (int i = 0; i < 8; i++) tick();
        stop = 1; tick(); stop = 0;

        // width 0 never drives out; width above period holds out high
        launch(0, 3, 0, 0);
        for (int i = 0; i < 8; i++) begin tick(); check("w0_out", int'(out), 0); end
        stop = 1; tick(); stop = 0;
        launch(0, 4, 9, 0);
        check("w9_first", int'(out), 1);
        for (int i = 0; i < 10; i++) begin tick(); check("w9_out", int'(out), 1); end
        stop = 1; tick(); stop = 0;

        // reset mid-burst, then stop mid-burst; each followed by a fresh burst
        launch(1, 3, 2, 4);
        for (int i = 0; i < 5; i++) tick();
        rst = 1; tick(); rst = 0;
        check("rst_mid_out", int'(out), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(done), 0);
        launch(1, 1, 1, 2);
        for (int i = 0; i < 6; i++) tick();
        launch(1, 3, 2, 4);
        for (int i = 0; i < 6; i++) tick();
        stop = 1; tick(); stop = 0;
        check("stop_mid_out", int'(out), 0);
        check("stop_mid_busy", int'(busy), 0);
        check("stop_mid_done", int'(done), 0);
        launch(1, 1, 1, 2);
        for (int i = 0; i < 6; i++) tick();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            ena    = ($urandom_range(0, 9) != 0);
            start  = ($urandom_range(0, 4) == 0);
            stop   = ($urandom_range(0, 29) == 0);
            mode   = 1'($urandom_range(0, 1));
            period = 8'($urandom_range(0, 6));
            width  = 8'($urandom_range(0, 8));
            burst  = 8'($urandom_range(0, 4));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
